// File: rtl/id_stage_pipe_if.sv
// id_stage_pipe_if -- bundle of signals between the ID pipeline register and
// its neighbours.
//
// Parameters:
//   DATA_W : operand/result width (16..64)
//   FUNC_W : width of the EXE command field
//
// Upstream side (decode/fetch into the stage):
//   instruction, registerval1, registerval2, ctl_* : beat payload inputs
//   in_valid / in_ready                            : upstream handshake
//   hazard_detected_in                             : stall request (blocks accept only)
//   flush                                          : squash buffered + incoming beats
//   src2_sel                                       : register-file read address for src2
// Downstream side (stage into EXE):
//   out_valid / out_ready                          : downstream handshake
//   valuein1, valuein2, st_val, source1, src2_forw,
//   dest, exe_cmd, mem_r, mem_w, wb_en             : head-entry ID/EX payload
//   br_taken                                       : registered branch-taken pulse
//   dbg_state                                      : buffer FSM state (0 EMPTY, 1 ONE, 2 TWO)
//
// Handshake rule, both sides: a beat moves on a rising clk edge where valid
// and ready are both 1. A producer holding valid keeps its payload stable
// until the transfer happens; ready may change without regard to valid.
// flush overrides both handshakes for the cycle in which it is high.
//
// Modports: slave is the pipeline stage's view, master is the view of
// whatever drives the stage (the surrounding pipeline, or a bench).
interface id_stage_pipe_if #(
  parameter int DATA_W = 32,
  parameter int FUNC_W = 4
);
  logic [31:0]       instruction;
  logic [DATA_W-1:0] registerval1;
  logic [DATA_W-1:0] registerval2;
  logic [FUNC_W-1:0] ctl_exe_cmd;
  logic              ctl_is_imm;
  logic              ctl_st_bne;
  logic              ctl_mem_r;
  logic              ctl_mem_w;
  logic              ctl_wb_en;
  logic [1:0]        ctl_br_cmd;
  logic              hazard_detected_in;
  logic              in_valid;
  logic              in_ready;
  logic              flush;
  logic [4:0]        src2_sel;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] valuein1;
  logic [DATA_W-1:0] valuein2;
  logic [DATA_W-1:0] st_val;
  logic [4:0]        source1;
  logic [4:0]        src2_forw;
  logic [4:0]        dest;
  logic [FUNC_W-1:0] exe_cmd;
  logic              mem_r;
  logic              mem_w;
  logic              wb_en;
  logic              br_taken;
  logic [1:0]        dbg_state;

  modport slave (
    input  instruction, registerval1, registerval2, ctl_exe_cmd, ctl_is_imm,
           ctl_st_bne, ctl_mem_r, ctl_mem_w, ctl_wb_en, ctl_br_cmd,
           hazard_detected_in, in_valid, flush, out_ready,
    output in_ready, src2_sel, out_valid, valuein1, valuein2, st_val, source1,
           src2_forw, dest, exe_cmd, mem_r, mem_w, wb_en, br_taken, dbg_state
  );

  modport master (
    output instruction, registerval1, registerval2, ctl_exe_cmd, ctl_is_imm,
           ctl_st_bne, ctl_mem_r, ctl_mem_w, ctl_wb_en, ctl_br_cmd,
           hazard_detected_in, in_valid, flush, out_ready,
    input  in_ready, src2_sel, out_valid, valuein1, valuein2, st_val, source1,
           src2_forw, dest, exe_cmd, mem_r, mem_w, wb_en, br_taken, dbg_state
  );
endinterface

// File: rtl/id_stage_pipe.sv
// id_stage_pipe -- ID/EX pipeline register built as a 2-entry skid buffer.
//
// A decoded beat (instruction fields, register-file data, pre-decoded
// control) is captured when in_valid & in_ready & ~flush. Up to two beats
// are held; the oldest (head) drives the ID/EX outputs. The branch condition
// of an accepted beat is evaluated at accept time and reported as a one-cycle
// br_taken pulse in the following cycle.
//
// Ports:
//   clk      : single clock, all state on the rising edge
//   reset    : asynchronous, active-low reset
//   bus      : id_stage_pipe_if.slave (handshakes, payload, control, debug)
//   br_count : 16-bit saturating count of br_taken pulses
//              (present only when ID_BR_CNT_EN is defined)
//
// Build option:
//   ID_BR_CNT_EN : adds the br_count output and its counter. The counter is
//                  cleared only by reset, never by flush.
module id_stage_pipe #(
  parameter int DATA_W = 32,
  parameter int FUNC_W = 4
) (
  input  logic           clk,
  input  logic           reset,
  id_stage_pipe_if.slave bus
`ifdef ID_BR_CNT_EN
  ,
  output logic [15:0]    br_count
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  // One buffered ID/EX beat.
  typedef struct packed {
    logic [DATA_W-1:0] v1;
    logic [DATA_W-1:0] v2;
    logic [DATA_W-1:0] st;
    logic [4:0]        s1;
    logic [4:0]        s2f;
    logic [4:0]        dst;
    logic [FUNC_W-1:0] cmd;
    logic              mem_r;
    logic              mem_w;
    logic              wb_en;
  } entry_t;

  state_t            state_q;
  state_t            state_d;
  entry_t            head_q;
  entry_t            tail_q;
  entry_t            in_entry;
  logic [DATA_W-1:0] imm_ext;
  logic              in_ready_int;
  logic              out_valid_int;
  logic              accept;
  logic              pop;
  logic              br_cond;
  logic              br_taken_q;
  logic              load_head_in;
  logic              load_head_tail;
  logic              load_tail;

  // ---------------------------------------------------------------------
  // Handshake qualifiers
  // ---------------------------------------------------------------------
  assign in_ready_int  = (state_q != S_TWO) & ~bus.hazard_detected_in;
  assign out_valid_int = (state_q != S_EMPTY);
  assign accept        = bus.in_valid & in_ready_int & ~bus.flush;
  assign pop           = out_valid_int & bus.out_ready;

  // ---------------------------------------------------------------------
  // Decode of the incoming beat
  // ---------------------------------------------------------------------
  // Size cast of a signed operand sign-extends and stays legal at DATA_W=16.
  assign imm_ext = DATA_W'($signed(bus.instruction[15:0]));

  // Stores and bne read rd's register as the second operand.
  assign bus.src2_sel = bus.ctl_st_bne ? bus.instruction[25:21]
                                       : bus.instruction[15:11];

  always_comb begin
    in_entry       = '0;
    in_entry.v1    = bus.registerval1;
    in_entry.v2    = bus.ctl_is_imm ? imm_ext : bus.registerval2;
    in_entry.st    = bus.registerval2;
    in_entry.s1    = bus.instruction[20:16];
    // An immediate operand has no register to forward into.
    in_entry.s2f   = bus.ctl_is_imm ? 5'd0 : bus.instruction[15:11];
    in_entry.dst   = bus.instruction[25:21];
    in_entry.cmd   = bus.ctl_exe_cmd;
    in_entry.mem_r = bus.ctl_mem_r;
    in_entry.mem_w = bus.ctl_mem_w;
    in_entry.wb_en = bus.ctl_wb_en;
  end

  always_comb begin
    br_cond = 1'b0;
    case (bus.ctl_br_cmd)
      2'd0:    br_cond = 1'b0;
      2'd1:    br_cond = (bus.registerval1 == '0);
      2'd2:    br_cond = (bus.registerval1 != bus.registerval2);
      default: br_cond = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------
  // Buffer FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    load_head_in   = 1'b0;
    load_head_tail = 1'b0;
    load_tail      = 1'b0;
    case (state_q)
      S_EMPTY: begin
        if (accept) begin
          state_d      = S_ONE;
          load_head_in = 1'b1;
        end
      end
      S_ONE: begin
        if (accept && !pop) begin
          state_d   = S_TWO;
          load_tail = 1'b1;
        end else if (!accept && pop) begin
          state_d = S_EMPTY;
        end else if (accept && pop) begin
          // Head leaves this cycle, the new beat takes its place directly.
          load_head_in = 1'b1;
        end
      end
      S_TWO: begin
        // in_ready is 0 here, so only a pop can happen.
        if (pop) begin
          state_d        = S_ONE;
          load_head_tail = 1'b1;
        end
      end
      default: begin
        state_d = S_EMPTY;
      end
    endcase
    // flush beats any simultaneous accept or pop.
    if (bus.flush) begin
      state_d        = S_EMPTY;
      load_head_in   = 1'b0;
      load_head_tail = 1'b0;
      load_tail      = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Payload storage. Entries are only written on accept/promote, so a held
  // head stays stable while the consumer stalls.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q <= '0;
    end else if (load_head_in) begin
      head_q <= in_entry;
    end else if (load_head_tail) begin
      head_q <= tail_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tail_q <= '0;
    end else if (load_tail) begin
      tail_q <= in_entry;
    end
  end

  // accept already excludes flush, so a flushed beat never pulses br_taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      br_taken_q <= 1'b0;
    end else begin
      br_taken_q <= accept & br_cond;
    end
  end

`ifdef ID_BR_CNT_EN
  logic [15:0] br_count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      br_count_q <= '0;
    end else if (br_taken_q && (br_count_q != 16'hFFFF)) begin
      br_count_q <= br_count_q + 16'd1;
    end
  end

  assign br_count = br_count_q;
`endif

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = out_valid_int;
  assign bus.valuein1  = head_q.v1;
  assign bus.valuein2  = head_q.v2;
  assign bus.st_val    = head_q.st;
  assign bus.source1   = head_q.s1;
  assign bus.src2_forw = head_q.s2f;
  assign bus.dest      = head_q.dst;
  assign bus.exe_cmd   = head_q.cmd;
  // Side-effecting controls read as a bubble when nothing is presented.
  assign bus.mem_r     = out_valid_int & head_q.mem_r;
  assign bus.mem_w     = out_valid_int & head_q.mem_w;
  assign bus.wb_en     = out_valid_int & head_q.wb_en;
  assign bus.br_taken  = br_taken_q;
  assign bus.dbg_state = state_q;

endmodule
